// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the RV32I pipeline and its hazard controller:
// stage status flows in, register load/hold/bubble controls and forwarding selects flow out.
interface pipe_hazard_ctrl_if;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic        id_use_rs1;
   logic        id_use_rs2;
   logic [4:0]  ex_rd;
   logic        ex_reg_write;
   logic        ex_load;
   logic [4:0]  mem_rd;
   logic        mem_reg_write;
   logic        mem_access;
   logic [4:0]  wb_rd;
   logic        wb_reg_write;
   logic        dmem_ack;
   logic        branch_taken;

   logic        if_stall;
   logic        ifid_stall;
   logic        idex_stall;
   logic        exmem_stall;
   logic        ifid_flush;
   logic        idex_flush;
   logic        memwb_flush;
   logic [1:0]  fwd_a;
   logic [1:0]  fwd_b;
   logic        mem_err;
   logic [31:0] perf_stall_cnt;
   logic [31:0] perf_flush_cnt;

   // Pipeline side: drives stage status, consumes the controls.
   modport master (
      output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
             ex_rd, ex_reg_write, ex_load,
             mem_rd, mem_reg_write, mem_access,
             wb_rd, wb_reg_write, dmem_ack, branch_taken,
      input  if_stall, ifid_stall, idex_stall, exmem_stall,
             ifid_flush, idex_flush, memwb_flush,
             fwd_a, fwd_b, mem_err, perf_stall_cnt, perf_flush_cnt
   );

   // Controller side.
   modport slave (
      input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
             ex_rd, ex_reg_write, ex_load,
             mem_rd, mem_reg_write, mem_access,
             wb_rd, wb_reg_write, dmem_ack, branch_taken,
      output if_stall, ifid_stall, idex_stall, exmem_stall,
             ifid_flush, idex_flush, memwb_flush,
             fwd_a, fwd_b, mem_err, perf_stall_cnt, perf_flush_cnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipe: stalls, bubbles, forwarding, memory-wait watchdog.
// Optional stall/flush performance counters are built only when HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input logic               clk,
   input logic               rst,
   pipe_hazard_ctrl_if.slave hz
);

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_e;

   localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

   state_e     state_q, state_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic       timed_out;
   logic       freeze;
   logic       load_use;
   logic       ex_fwd_ok;

   // Youngest producer wins; x0 and unread operands never forward.
   function automatic logic [1:0] fwd_sel(
      input logic [4:0] rs,
      input logic       use_rs,
      input logic [4:0] ex_rd,
      input logic       ex_ok,
      input logic [4:0] mem_rd,
      input logic       mem_wr,
      input logic [4:0] wb_rd,
      input logic       wb_wr
   );
      logic [1:0] sel;
      sel = 2'b00;
      if (use_rs && rs != 5'd0) begin
         if (ex_ok && ex_rd == rs)        sel = 2'b01;
         else if (mem_wr && mem_rd == rs) sel = 2'b10;
         else if (wb_wr && wb_rd == rs)   sel = 2'b11;
      end
      return sel;
   endfunction

   // An ack arriving in the timeout cycle completes the access instead of faulting it.
   assign timed_out = (state_q == MEM_WAIT) && (wait_cnt_q == TIMEOUT_C) && !hz.dmem_ack;
   assign freeze    = hz.mem_access && !hz.dmem_ack && !timed_out;
   assign ex_fwd_ok = hz.ex_reg_write && !hz.ex_load;

   assign load_use = hz.ex_load && hz.ex_reg_write && (hz.ex_rd != 5'd0) &&
                     ((hz.id_use_rs1 && hz.id_rs1 == hz.ex_rd) ||
                      (hz.id_use_rs2 && hz.id_rs2 == hz.ex_rd));

   always_comb begin
      // NOTE: every output gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
      hz.if_stall    = 1'b0;
      hz.ifid_stall  = 1'b0;
      hz.idex_stall  = 1'b0;
      hz.exmem_stall = 1'b0;
      hz.ifid_flush  = 1'b0;
      hz.idex_flush  = 1'b0;
      hz.memwb_flush = 1'b0;
      hz.mem_err     = timed_out;
      hz.fwd_a       = fwd_sel(hz.id_rs1, hz.id_use_rs1, hz.ex_rd, ex_fwd_ok,
                               hz.mem_rd, hz.mem_reg_write, hz.wb_rd, hz.wb_reg_write);
      hz.fwd_b       = fwd_sel(hz.id_rs2, hz.id_use_rs2, hz.ex_rd, ex_fwd_ok,
                               hz.mem_rd, hz.mem_reg_write, hz.wb_rd, hz.wb_reg_write);

      if (rst) begin
         hz.ifid_flush = 1'b1;
         hz.idex_flush = 1'b1;
         hz.mem_err    = 1'b0;
         hz.fwd_a      = 2'b00;
         hz.fwd_b      = 2'b00;
      end else if (freeze) begin
         hz.if_stall    = 1'b1;
         hz.ifid_stall  = 1'b1;
         hz.idex_stall  = 1'b1;
         hz.exmem_stall = 1'b1;
         hz.memwb_flush = 1'b1;
      end else if (hz.branch_taken) begin
         // A branch held in a frozen EX stage lands here on the first released cycle.
         hz.ifid_flush = 1'b1;
         hz.idex_flush = 1'b1;
      end else if (load_use) begin
         hz.if_stall   = 1'b1;
         hz.ifid_stall = 1'b1;
         hz.idex_flush = 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      unique case (state_q)
         RUN: begin
            if (freeze) begin
               state_d    = MEM_WAIT;
               wait_cnt_d = 8'd1;
            end
         end
         MEM_WAIT: begin
            if (hz.dmem_ack || timed_out) begin
               state_d    = RUN;
               wait_cnt_d = 8'd0;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         default: begin
            state_d    = RUN;
            wait_cnt_d = 8'd0;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RUN;
         wait_cnt_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] flush_cnt_q;
   logic        branch_flush;

   assign branch_flush = !rst && !freeze && hz.branch_taken;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         if (hz.if_stall && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_q <= stall_cnt_q + 32'd1;
         if (branch_flush && flush_cnt_q != 32'hFFFF_FFFF) flush_cnt_q <= flush_cnt_q + 32'd1;
      end
   end

   assign hz.perf_stall_cnt = stall_cnt_q;
   assign hz.perf_flush_cnt = flush_cnt_q;
`else
   assign hz.perf_stall_cnt = 32'd0;
   assign hz.perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MEM_TIMEOUT=4); perf expectations follow HAZARD_PERF_EN.
module tb_pipe_hazard_ctrl;

`ifdef HAZARD_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic clk;
   logic rst;
   int   n_err;
   int   n_chk;
   int   exp_stall;
   int   exp_flush;

   pipe_hazard_ctrl_if hif ();

   pipe_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hif)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      hif.id_rs1 = 5'd0;  hif.id_rs2 = 5'd0;
      hif.id_use_rs1 = 1'b0; hif.id_use_rs2 = 1'b0;
      hif.ex_rd = 5'd0;   hif.ex_reg_write = 1'b0; hif.ex_load = 1'b0;
      hif.mem_rd = 5'd0;  hif.mem_reg_write = 1'b0; hif.mem_access = 1'b0;
      hif.wb_rd = 5'd0;   hif.wb_reg_write = 1'b0;
      hif.dmem_ack = 1'b0; hif.branch_taken = 1'b0;
   endtask

   task automatic check_freeze(input string tag, input logic f);
      check({tag, ".if_stall"},    {31'd0, hif.if_stall},    {31'd0, f});
      check({tag, ".ifid_stall"},  {31'd0, hif.ifid_stall},  {31'd0, f});
      check({tag, ".idex_stall"},  {31'd0, hif.idex_stall},  {31'd0, f});
      check({tag, ".exmem_stall"}, {31'd0, hif.exmem_stall}, {31'd0, f});
      check({tag, ".memwb_flush"}, {31'd0, hif.memwb_flush}, {31'd0, f});
   endtask

   task automatic check_perf(input string tag);
      check({tag, ".perf_stall"}, hif.perf_stall_cnt, PERF ? 32'(exp_stall) : 32'd0);
      check({tag, ".perf_flush"}, hif.perf_flush_cnt, PERF ? 32'(exp_flush) : 32'd0);
   endtask

   initial begin
      clk = 1'b0;
      n_err = 0; n_chk = 0; exp_stall = 0; exp_flush = 0;
      clear_inputs();

      // Reset: flushes only, forwarding suppressed even with a matching producer.
      rst = 1'b1;
      hif.ex_rd = 5'd1; hif.ex_reg_write = 1'b1; hif.id_rs1 = 5'd1; hif.id_use_rs1 = 1'b1;
      step(); step();
      check("rst.ifid_flush", {31'd0, hif.ifid_flush}, 32'd1);
      check("rst.idex_flush", {31'd0, hif.idex_flush}, 32'd1);
      check_freeze("rst", 1'b0);
      check("rst.fwd_a", {30'd0, hif.fwd_a}, 32'd0);
      check("rst.mem_err", {31'd0, hif.mem_err}, 32'd0);
      rst = 1'b0;
      clear_inputs();
      step();
      check_perf("post_rst");

      // Forwarding priority on operand B; operand A reads r3 but is unused.
      hif.ex_rd = 5'd3;  hif.ex_reg_write = 1'b1;
      hif.mem_rd = 5'd3; hif.mem_reg_write = 1'b1;
      hif.wb_rd = 5'd3;  hif.wb_reg_write = 1'b1;
      hif.id_rs2 = 5'd3; hif.id_use_rs2 = 1'b1; hif.id_rs1 = 5'd3;
      #1;
      check("fwd.ex", {30'd0, hif.fwd_b}, 32'd1);
      check("fwd.unused_a", {30'd0, hif.fwd_a}, 32'd0);
      check("fwd.no_stall", {31'd0, hif.if_stall}, 32'd0);
      hif.ex_reg_write = 1'b0;
      #1;
      check("fwd.mem", {30'd0, hif.fwd_b}, 32'd2);
      hif.mem_reg_write = 1'b0;
      #1;
      check("fwd.wb", {30'd0, hif.fwd_b}, 32'd3);
      hif.ex_reg_write = 1'b1; hif.mem_reg_write = 1'b1;
      hif.ex_rd = 5'd0; hif.mem_rd = 5'd0; hif.wb_rd = 5'd0; hif.id_rs2 = 5'd0;
      #1;
      check("fwd.x0", {30'd0, hif.fwd_b}, 32'd0);
      step();
      clear_inputs();

      // Non-hazards: load to x0, load-dest matching an unread operand.
      hif.ex_load = 1'b1; hif.ex_reg_write = 1'b1; hif.ex_rd = 5'd0;
      hif.id_rs1 = 5'd0; hif.id_use_rs1 = 1'b1;
      #1;
      check("lu.x0", {31'd0, hif.if_stall}, 32'd0);
      hif.ex_rd = 5'd7; hif.id_rs2 = 5'd7; hif.id_use_rs2 = 1'b0;
      #1;
      check("lu.unused", {31'd0, hif.if_stall}, 32'd0);
      step();
      clear_inputs();

      // Load-use: one bubble, then the load forwards from MEM.
      hif.ex_load = 1'b1; hif.ex_reg_write = 1'b1; hif.ex_rd = 5'd5;
      hif.id_rs1 = 5'd5; hif.id_use_rs1 = 1'b1;
      #1;
      check("lu.if_stall", {31'd0, hif.if_stall}, 32'd1);
      check("lu.ifid_stall", {31'd0, hif.ifid_stall}, 32'd1);
      check("lu.idex_flush", {31'd0, hif.idex_flush}, 32'd1);
      check("lu.idex_stall", {31'd0, hif.idex_stall}, 32'd0);
      check("lu.ifid_flush", {31'd0, hif.ifid_flush}, 32'd0);
      check("lu.fwd_a", {30'd0, hif.fwd_a}, 32'd0);
      step();
      exp_stall++;
      hif.ex_load = 1'b0; hif.ex_reg_write = 1'b0; hif.ex_rd = 5'd0;
      hif.mem_rd = 5'd5; hif.mem_reg_write = 1'b1;
      #1;
      check("lu_next.fwd_a", {30'd0, hif.fwd_a}, 32'd2);
      check("lu_next.if_stall", {31'd0, hif.if_stall}, 32'd0);
      check_perf("lu_next");
      step();
      clear_inputs();

      // Branch masks a simultaneous load-use.
      hif.ex_load = 1'b1; hif.ex_reg_write = 1'b1; hif.ex_rd = 5'd9;
      hif.id_rs2 = 5'd9; hif.id_use_rs2 = 1'b1; hif.branch_taken = 1'b1;
      #1;
      check("br.ifid_flush", {31'd0, hif.ifid_flush}, 32'd1);
      check("br.idex_flush", {31'd0, hif.idex_flush}, 32'd1);
      check("br.if_stall", {31'd0, hif.if_stall}, 32'd0);
      check("br.ifid_stall", {31'd0, hif.ifid_stall}, 32'd0);
      check_perf("br_before");
      step();
      exp_flush++;
      clear_inputs();
      #1;
      check_perf("br_after");

      // Ack in the first access cycle: no freeze.
      hif.mem_access = 1'b1; hif.dmem_ack = 1'b1;
      #1;
      check_freeze("ack0", 1'b0);
      step();
      clear_inputs();

      // Memory wait: three frozen cycles then ack.
      hif.mem_access = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         #1;
         check_freeze($sformatf("mw%0d", c), 1'b1);
         check($sformatf("mw%0d.ifid_flush", c), {31'd0, hif.ifid_flush}, 32'd0);
         step();
         exp_stall++;
      end
      hif.dmem_ack = 1'b1;
      #1;
      check_freeze("mw_ack", 1'b0);
      check("mw_ack.mem_err", {31'd0, hif.mem_err}, 32'd0);
      step();
      clear_inputs();
      #1;
      check_perf("mw_done");

      // Timeout with a held branch: four frozen cycles, then one mem_err cycle that applies the flush.
      hif.mem_access = 1'b1; hif.branch_taken = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         #1;
         check_freeze($sformatf("to%0d", c), 1'b1);
         check($sformatf("to%0d.mem_err", c), {31'd0, hif.mem_err}, 32'd0);
         check($sformatf("to%0d.ifid_flush", c), {31'd0, hif.ifid_flush}, 32'd0);
         step();
         exp_stall++;
      end
      #1;
      check("to5.mem_err", {31'd0, hif.mem_err}, 32'd1);
      check_freeze("to5", 1'b0);
      check("to5.ifid_flush", {31'd0, hif.ifid_flush}, 32'd1);
      check("to5.idex_flush", {31'd0, hif.idex_flush}, 32'd1);
      step();
      exp_flush++;
      clear_inputs();
      #1;
      check("to6.mem_err", {31'd0, hif.mem_err}, 32'd0);
      check_perf("to6");
      step();

      // Ack arriving in the timeout cycle wins over mem_err.
      hif.mem_access = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         step();
         exp_stall++;
      end
      hif.dmem_ack = 1'b1;
      #1;
      check("tack.mem_err", {31'd0, hif.mem_err}, 32'd0);
      check_freeze("tack", 1'b0);
      step();
      clear_inputs();
      #1;
      check_perf("tack_done");

      // Reset in wait cycle 2; afterwards a fresh access must take the full timeout.
      hif.mem_access = 1'b1;
      step();
      rst = 1'b1;
      #1;
      check("rstw.ifid_flush", {31'd0, hif.ifid_flush}, 32'd1);
      check("rstw.idex_flush", {31'd0, hif.idex_flush}, 32'd1);
      check_freeze("rstw", 1'b0);
      check("rstw.mem_err", {31'd0, hif.mem_err}, 32'd0);
      step();
      rst = 1'b0;
      exp_stall = 0;
      exp_flush = 0;
      #1;
      check_perf("rstw_clear");
      for (int c = 1; c <= 4; c++) begin
         #1;
         check($sformatf("rstw_to%0d.mem_err", c), {31'd0, hif.mem_err}, 32'd0);
         check($sformatf("rstw_to%0d.if_stall", c), {31'd0, hif.if_stall}, 32'd1);
         step();
         exp_stall++;
      end
      #1;
      check("rstw_to5.mem_err", {31'd0, hif.mem_err}, 32'd1);
      step();
      clear_inputs();
      #1;
      check_perf("final");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
